// File: rtl/video_fetch_if.sv
// Video read port between the fetch engine (master) and the RAM arbiter (slave).
// The master registers request, target and address; the arbiter answers with ack, then valid + vd.
interface video_fetch_if;
  logic        video_read_req;
  logic        video_read_req_is_up;
  logic [14:0] video_read_addr;
  logic        video_read_req_ack;
  logic        video_data_valid;
  logic [7:0]  vd;

  modport master (
    output video_read_req, video_read_req_is_up, video_read_addr,
    input  video_read_req_ack, video_data_valid, vd
  );

  modport slave (
    input  video_read_req, video_read_req_is_up, video_read_addr,
    output video_read_req_ack, video_data_valid, vd
  );
endinterface

// File: rtl/video_fetch.sv
// Per-cell video fetch: bitmap, attribute and optional ULA+ ink/paper reads.
// Steps on arbiter ack, captures on data-valid, and emits one cell record with a ready strobe.
module video_fetch #(
  parameter int UP_ENABLE = 1
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        fetch_strobe,
  input  logic [4:0]  fetch_x,
  input  logic [7:0]  fetch_y,
  input  logic        up_en,
  video_fetch_if.master vram,
  output logic        busy,
  output logic        cell_ready,
  output logic [7:0]  cell_bitmap,
  output logic [7:0]  cell_attr,
  output logic [7:0]  cell_ink,
  output logic [7:0]  cell_paper,
  output logic        overrun
);

  // The tag reuses the state encoding; IDLE means no read in flight.
  typedef enum logic [2:0] {IDLE, BMP, ATTR, INK, PAPER, DRAIN} state_t;

  state_t      state_reg, state_next;
  state_t      tag_reg, tag_next;
  logic [4:0]  x_reg, x_next;
  logic [7:0]  y_reg, y_next;
  logic        up_reg, up_next;
  logic        req_reg, req_next;
  logic        is_up_reg, is_up_next;
  logic [14:0] addr_reg, addr_next;
  logic [7:0]  bitmap_reg, bitmap_next;
  logic [7:0]  attr_reg, attr_next;
  logic [7:0]  ink_reg, ink_next;
  logic [7:0]  paper_reg, paper_next;
  logic [7:0]  cell_bitmap_reg, cell_bitmap_next;
  logic [7:0]  cell_attr_reg, cell_attr_next;
  logic [7:0]  cell_ink_reg, cell_ink_next;
  logic [7:0]  cell_paper_reg, cell_paper_next;
  logic        cell_ready_reg, cell_ready_next;
  logic        overrun_reg, overrun_next;
  logic        ack_ok;
  logic        capture;

  function automatic logic [14:0] bitmap_addr(input logic [4:0] x, input logic [7:0] y);
    return {2'b00, y[7:6], y[2:0], y[5:3], x};
  endfunction

  function automatic logic [14:0] attr_addr(input logic [4:0] x, input logic [7:0] y);
    return {2'b00, 3'b110, y[7:3], x};
  endfunction

  function automatic logic [14:0] ink_index(input logic [7:0] a);
    return {9'd0, a[7:6], 1'b0, a[2:0]};
  endfunction

  function automatic logic [14:0] paper_index(input logic [7:0] a);
    return {9'd0, a[7:6], 1'b1, a[5:3]};
  endfunction

  always_comb begin
    state_next       = state_reg;
    tag_next         = tag_reg;
    x_next           = x_reg;
    y_next           = y_reg;
    up_next          = up_reg;
    req_next         = req_reg;
    is_up_next       = is_up_reg;
    addr_next        = addr_reg;
    bitmap_next      = bitmap_reg;
    attr_next        = attr_reg;
    ink_next         = ink_reg;
    paper_next       = paper_reg;
    cell_bitmap_next = cell_bitmap_reg;
    cell_attr_next   = cell_attr_reg;
    cell_ink_next    = cell_ink_reg;
    cell_paper_next  = cell_paper_reg;
    cell_ready_next  = 1'b0;
    overrun_next     = overrun_reg;

    ack_ok  = vram.video_read_req_ack && req_reg;
    capture = vram.video_data_valid && (tag_reg != IDLE);

    // Capture first so an ack at the same edge can overwrite the tag.
    if (capture) begin
      tag_next = IDLE;
      case (tag_reg)
        BMP:     bitmap_next = vram.vd;
        ATTR:    attr_next   = vram.vd;
        INK:     ink_next    = vram.vd;
        PAPER:   paper_next  = vram.vd;
        default: ;
      endcase
    end

    case (state_reg)
      IDLE: begin
        if (fetch_strobe) begin
          x_next     = fetch_x;
          y_next     = fetch_y;
          up_next    = up_en && (UP_ENABLE != 0);
          state_next = BMP;
          req_next   = 1'b1;
          is_up_next = 1'b0;
          addr_next  = bitmap_addr(fetch_x, fetch_y);
        end
      end
      BMP: begin
        if (ack_ok) begin
          tag_next   = BMP;
          state_next = ATTR;
          addr_next  = attr_addr(x_reg, y_reg);
        end
      end
      ATTR: begin
        if (ack_ok) begin
          tag_next   = ATTR;
          state_next = up_reg ? INK : DRAIN;
          req_next   = 1'b0;
          is_up_next = 1'b0;
        end
      end
      INK: begin
        if (ack_ok) begin
          tag_next   = INK;
          state_next = PAPER;
          addr_next  = paper_index(attr_reg);
        end
      end
      PAPER: begin
        if (ack_ok) begin
          tag_next   = PAPER;
          state_next = DRAIN;
          req_next   = 1'b0;
          is_up_next = 1'b0;
        end
      end
      default: ;
    endcase

    // The ink index depends on the attribute byte, so arm the palette read as it lands.
    if (state_reg == INK && !req_reg && capture && tag_reg == ATTR) begin
      req_next   = 1'b1;
      is_up_next = 1'b1;
      addr_next  = ink_index(vram.vd);
    end

    if (capture && ((tag_reg == ATTR && !up_reg) || tag_reg == PAPER)) begin
      state_next       = IDLE;
      cell_ready_next  = 1'b1;
      cell_bitmap_next = bitmap_next;
      cell_attr_next   = attr_next;
      cell_ink_next    = up_reg ? ink_next : 8'd0;
      cell_paper_next  = up_reg ? paper_next : 8'd0;
    end

    if (fetch_strobe && state_reg != IDLE) begin
      overrun_next = 1'b1;
    end
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      tag_reg         <= IDLE;
      x_reg           <= '0;
      y_reg           <= '0;
      up_reg          <= 1'b0;
      req_reg         <= 1'b0;
      is_up_reg       <= 1'b0;
      addr_reg        <= '0;
      bitmap_reg      <= '0;
      attr_reg        <= '0;
      ink_reg         <= '0;
      paper_reg       <= '0;
      cell_bitmap_reg <= '0;
      cell_attr_reg   <= '0;
      cell_ink_reg    <= '0;
      cell_paper_reg  <= '0;
      cell_ready_reg  <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      tag_reg         <= tag_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      up_reg          <= up_next;
      req_reg         <= req_next;
      is_up_reg       <= is_up_next;
      addr_reg        <= addr_next;
      bitmap_reg      <= bitmap_next;
      attr_reg        <= attr_next;
      ink_reg         <= ink_next;
      paper_reg       <= paper_next;
      cell_bitmap_reg <= cell_bitmap_next;
      cell_attr_reg   <= cell_attr_next;
      cell_ink_reg    <= cell_ink_next;
      cell_paper_reg  <= cell_paper_next;
      cell_ready_reg  <= cell_ready_next;
      overrun_reg     <= overrun_next;
    end
  end

  assign vram.video_read_req       = req_reg;
  assign vram.video_read_req_is_up = is_up_reg;
  assign vram.video_read_addr      = addr_reg;
  assign busy        = (state_reg != IDLE);
  assign cell_ready  = cell_ready_reg;
  assign cell_bitmap = cell_bitmap_reg;
  assign cell_attr   = cell_attr_reg;
  assign cell_ink    = cell_ink_reg;
  assign cell_paper  = cell_paper_reg;
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_video_fetch.sv
// Directed bench for video_fetch: table of cell fetches against a small arbiter model,
// plus hand-written back-to-back, overrun and mid-sequence reset sequences.
module tb_video_fetch;

  typedef struct {
    logic [4:0]  x;
    logic [7:0]  y;
    logic        up;
    int          stall;
    int          nreq;
    logic [31:0] d;     // returned bytes, first read in [31:24]
    logic [63:0] req;   // {is_up, addr} per read, first read in [63:48]
    logic [7:0]  e_bmp, e_attr, e_ink, e_paper;
  } vec_t;

  logic       clk28 = 1'b0;
  logic       rst_n = 1'b0;
  logic       fetch_strobe = 1'b0;
  logic [4:0] fetch_x = '0;
  logic [7:0] fetch_y = '0;
  logic       up_en = 1'b0;
  logic       busy, cell_ready, overrun;
  logic [7:0] cell_bitmap, cell_attr, cell_ink, cell_paper;
  logic       busy0, cell_ready0, overrun0;
  logic [7:0] cell_bitmap0, cell_attr0, cell_ink0, cell_paper0;

  video_fetch_if vif ();
  video_fetch_if vif0 ();

  video_fetch #(.UP_ENABLE(1)) dut (
    .clk28(clk28), .rst_n(rst_n), .fetch_strobe(fetch_strobe), .fetch_x(fetch_x),
    .fetch_y(fetch_y), .up_en(up_en), .vram(vif), .busy(busy), .cell_ready(cell_ready),
    .cell_bitmap(cell_bitmap), .cell_attr(cell_attr), .cell_ink(cell_ink),
    .cell_paper(cell_paper), .overrun(overrun)
  );

  video_fetch #(.UP_ENABLE(0)) dut0 (
    .clk28(clk28), .rst_n(rst_n), .fetch_strobe(fetch_strobe), .fetch_x(fetch_x),
    .fetch_y(fetch_y), .up_en(up_en), .vram(vif0), .busy(busy0), .cell_ready(cell_ready0),
    .cell_bitmap(cell_bitmap0), .cell_attr(cell_attr0), .cell_ink(cell_ink0),
    .cell_paper(cell_paper0), .overrun(overrun0)
  );

  always #5 clk28 = ~clk28;

  int checks = 0;
  int errors = 0;

  // Arbiter model for dut, with a manual override used by the reset sequence.
  logic        arb_ack = 1'b0, arb_valid = 1'b0;
  logic [7:0]  arb_vd = '0;
  logic        man_mode = 1'b0, man_ack = 1'b0, man_valid = 1'b0;
  logic [7:0]  man_vd = '0;
  logic        pend = 1'b0;
  logic [7:0]  resp_q[$];
  logic [15:0] log_q[$];
  int          stall_n = 0;
  int          stall_seen = 0;
  logic [14:0] stall_addr = '0;
  int          ready_cnt = 0;

  assign vif.video_read_req_ack = man_mode ? man_ack   : arb_ack;
  assign vif.video_data_valid   = man_mode ? man_valid : arb_valid;
  assign vif.vd                 = man_mode ? man_vd    : arb_vd;

  always @(negedge clk28) begin
    arb_ack   = 1'b0;
    arb_valid = 1'b0;
    if (!man_mode) begin
      if (pend) begin
        arb_valid = 1'b1;
        arb_vd    = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hEE;
        pend      = 1'b0;
      end
      if (vif.video_read_req) begin
        if (stall_n > 0 && vif.video_read_addr == stall_addr) begin
          stall_n--;
          stall_seen++;
        end else begin
          arb_ack = 1'b1;
          pend    = 1'b1;
          log_q.push_back({vif.video_read_req_is_up, vif.video_read_addr});
        end
      end
    end
  end

  always @(negedge clk28) begin
    if (cell_ready) ready_cnt++;
  end

  // Always-granting arbiter for the UP_ENABLE=0 instance; returns an attribute with palette bits set.
  logic ack0 = 1'b0, valid0 = 1'b0, pend0 = 1'b0, up_seen0 = 1'b0;
  always @(negedge clk28) begin
    valid0 = pend0;
    pend0  = 1'b0;
    ack0   = 1'b0;
    if (vif0.video_read_req) begin
      ack0  = 1'b1;
      pend0 = 1'b1;
      if (vif0.video_read_req_is_up) up_seen0 = 1'b1;
    end
  end
  assign vif0.video_read_req_ack = ack0;
  assign vif0.video_data_valid   = valid0;
  assign vif0.vd                 = 8'hD6;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic start(input logic [4:0] x, input logic [7:0] y, input logic up);
    fetch_x = x;
    fetch_y = y;
    up_en = up;
    fetch_strobe = 1'b1;
    @(negedge clk28);
    fetch_strobe = 1'b0;
  endtask

  task automatic wait_ready(output int lat, output bit ok);
    lat = 1;
    ok = 1'b0;
    while (lat < 60) begin
      if (cell_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk28);
      lat++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=none required=cell_ready");
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    bit ok;
    int r0, s0;
    log_q.delete();
    resp_q.delete();
    for (int i = 0; i < v.nreq; i++) resp_q.push_back(v.d[31-8*i -: 8]);
    stall_addr = v.req[46:32];
    stall_n = v.stall;
    r0 = ready_cnt;
    s0 = stall_seen;
    start(v.x, v.y, v.up);
    wait_ready(lat, ok);
    if (ok) begin
      chk($sformatf("v%0d_bitmap", idx), {24'd0, cell_bitmap}, {24'd0, v.e_bmp});
      chk($sformatf("v%0d_attr", idx), {24'd0, cell_attr}, {24'd0, v.e_attr});
      chk($sformatf("v%0d_ink", idx), {24'd0, cell_ink}, {24'd0, v.e_ink});
      chk($sformatf("v%0d_paper", idx), {24'd0, cell_paper}, {24'd0, v.e_paper});
      chk($sformatf("v%0d_busy_done", idx), {31'd0, busy}, 32'd0);
      if (v.stall == 0)
        chk($sformatf("v%0d_latency_ok", idx), {31'd0, (lat <= (v.up ? 10 : 6))}, 32'd1);
    end
    repeat (3) @(negedge clk28);
    chk($sformatf("v%0d_ready_pulses", idx), ready_cnt - r0, 32'd1);
    chk($sformatf("v%0d_stall_cycles", idx), stall_seen - s0, v.stall);
    chk($sformatf("v%0d_resp_left", idx), resp_q.size(), 32'd0);
    chk($sformatf("v%0d_nreq", idx), log_q.size(), v.nreq);
    for (int i = 0; i < v.nreq && i < log_q.size(); i++)
      chk($sformatf("v%0d_req%0d", idx, i), {16'd0, log_q[i]}, {16'd0, v.req[63-16*i -: 16]});
    chk($sformatf("v%0d_noup_ink", idx), {24'd0, cell_ink0}, 32'd0);
    chk($sformatf("v%0d_noup_paper", idx), {24'd0, cell_paper0}, 32'd0);
    chk($sformatf("v%0d_noup_bitmap", idx), {24'd0, cell_bitmap0}, 32'h0000_00D6);
    $display("vec %0d x=%0d y=%0d up=%0d bitmap=%h attr=%h ink=%h paper=%h lat=%0d",
             idx, v.x, v.y, v.up, cell_bitmap, cell_attr, cell_ink, cell_paper, lat);
  endtask

  vec_t vecs[6];

  initial begin
    int lat;
    bit ok;
    int r0;

    vecs[0] = '{x:5'd5,  y:8'h47, up:1'b0, stall:0, nreq:2, d:32'hAA38_0000,
                req:64'h0F05_1905_0000_0000, e_bmp:8'hAA, e_attr:8'h38, e_ink:8'h00, e_paper:8'h00};
    vecs[1] = '{x:5'd5,  y:8'h47, up:1'b1, stall:0, nreq:4, d:32'hAAD6_1CE0,
                req:64'h0F05_1905_8036_803A, e_bmp:8'hAA, e_attr:8'hD6, e_ink:8'h1C, e_paper:8'hE0};
    vecs[2] = '{x:5'd5,  y:8'h47, up:1'b0, stall:5, nreq:2, d:32'h5538_0000,
                req:64'h0F05_1905_0000_0000, e_bmp:8'h55, e_attr:8'h38, e_ink:8'h00, e_paper:8'h00};
    vecs[3] = '{x:5'd31, y:8'hBF, up:1'b0, stall:0, nreq:2, d:32'h0F47_0000,
                req:64'h17FF_1AFF_0000_0000, e_bmp:8'h0F, e_attr:8'h47, e_ink:8'h00, e_paper:8'h00};
    vecs[4] = '{x:5'd31, y:8'hBF, up:1'b1, stall:0, nreq:4, d:32'h8147_1122,
                req:64'h17FF_1AFF_8017_8018, e_bmp:8'h81, e_attr:8'h47, e_ink:8'h11, e_paper:8'h22};
    vecs[5] = '{x:5'd0,  y:8'h00, up:1'b1, stall:0, nreq:4, d:32'h00FF_3344,
                req:64'h0000_1800_8037_803F, e_bmp:8'h00, e_attr:8'hFF, e_ink:8'h33, e_paper:8'h44};

    repeat (3) @(negedge clk28);
    rst_n = 1'b1;
    @(negedge clk28);
    chk("reset_req", {31'd0, vif.video_read_req}, 32'd0);
    chk("reset_is_up", {31'd0, vif.video_read_req_is_up}, 32'd0);
    chk("reset_addr", {17'd0, vif.video_read_addr}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ready", {31'd0, cell_ready}, 32'd0);
    chk("reset_cells", {cell_bitmap, cell_attr, cell_ink, cell_paper}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
    chk("noup_never_is_up", {31'd0, up_seen0}, 32'd0);

    // Strobe accepted while cell_ready is high.
    log_q.delete();
    resp_q.delete();
    resp_q.push_back(8'h0F); resp_q.push_back(8'h47);
    resp_q.push_back(8'hAA); resp_q.push_back(8'h38);
    start(5'd31, 8'hBF, 1'b0);
    wait_ready(lat, ok);
    chk("b2b_first_bitmap", {24'd0, cell_bitmap}, 32'h0000_000F);
    start(5'd5, 8'h47, 1'b0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_overrun", {31'd0, overrun}, 32'd0);
    wait_ready(lat, ok);
    chk("b2b_second_bitmap", {24'd0, cell_bitmap}, 32'h0000_00AA);
    chk("b2b_second_attr", {24'd0, cell_attr}, 32'h0000_0038);
    chk("b2b_nreq", log_q.size(), 32'd4);
    if (log_q.size() == 4) chk("b2b_req2", {16'd0, log_q[2]}, 32'h0000_0F05);
    $display("b2b bitmap=%h attr=%h", cell_bitmap, cell_attr);
    repeat (3) @(negedge clk28);

    // Second strobe while busy is dropped and flags overrun.
    log_q.delete();
    resp_q.delete();
    resp_q.push_back(8'hAA); resp_q.push_back(8'hD6);
    resp_q.push_back(8'h1C); resp_q.push_back(8'hE0);
    start(5'd5, 8'h47, 1'b1);
    @(negedge clk28);
    start(5'd0, 8'h00, 1'b0);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    wait_ready(lat, ok);
    chk("ovr_cell", {cell_bitmap, cell_attr, cell_ink, cell_paper}, 32'hAAD6_1CE0);
    chk("ovr_nreq", log_q.size(), 32'd4);
    if (log_q.size() == 4) begin
      chk("ovr_req0", {16'd0, log_q[0]}, 32'h0000_0F05);
      chk("ovr_req2", {16'd0, log_q[2]}, 32'h0000_8036);
    end
    repeat (3) @(negedge clk28);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    $display("overrun cell=%h overrun=%0d", {cell_bitmap, cell_attr, cell_ink, cell_paper}, overrun);

    // Reset after the bitmap ack; a late data-valid must be ignored.
    man_mode = 1'b1;
    @(negedge clk28);
    r0 = ready_cnt;
    start(5'd5, 8'h47, 1'b0);
    chk("rst_seq_req", {31'd0, vif.video_read_req}, 32'd1);
    man_ack = 1'b1;
    @(negedge clk28);
    man_ack = 1'b0;
    rst_n = 1'b0;
    @(negedge clk28);
    rst_n = 1'b1;
    man_valid = 1'b1;
    man_vd = 8'hFF;
    @(negedge clk28);
    man_valid = 1'b0;
    repeat (3) @(negedge clk28);
    chk("rst_seq_req_low", {31'd0, vif.video_read_req}, 32'd0);
    chk("rst_seq_addr", {17'd0, vif.video_read_addr}, 32'd0);
    chk("rst_seq_busy", {31'd0, busy}, 32'd0);
    chk("rst_seq_cells", {cell_bitmap, cell_attr, cell_ink, cell_paper}, 32'd0);
    chk("rst_seq_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_seq_no_ready", ready_cnt - r0, 32'd0);
    $display("reset seq req=%0d busy=%0d cells=%h", vif.video_read_req, busy,
             {cell_bitmap, cell_attr, cell_ink, cell_paper});
    man_mode = 1'b0;
    @(negedge clk28);
    run_vec(6, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_fetch.md
Name: video_fetch

Overview:
- Video memory fetch engine that sits directly upstream of the RAM arbiter's video read port.
- Per 8-pixel character cell it issues a sequence of video reads: bitmap byte, attribute byte and, optionally, ULA+ ink and paper palette entries.
- It steps the sequence on the arbiter's ack and captures returned data on the arbiter's data-valid.
- It delivers one complete cell record to the pixel shifter and raises a one-cycle ready strobe.

Parameters:
UP_ENABLE, 1, when 0 the ink/paper palette fetches are never generated, regardless of up_en.

Ports:
clk28  input  1  system clock (28 MHz)
rst_n  input  1  reset, synchronous, active-low
fetch_strobe  input  1  one-cycle request to fetch a cell
fetch_x  input  5  cell column 0..31, sampled with fetch_strobe
fetch_y  input  8  pixel line 0..191, sampled with fetch_strobe
up_en  input  1  ULA+ palette mode, sampled with fetch_strobe
video_read_req  output  1  read request to arbiter (registered)
video_read_req_is_up  output  1  current request targets palette RAM (registered)
video_read_addr  output  15  screen offset, or palette index in [5:0] (registered)
video_read_req_ack  input  1  arbiter accepted current address
video_data_valid  input  1  vd carries data of the accepted read
vd  input  8  RAM data bus
busy  output  1  sequence in progress
cell_ready  output  1  one-cycle strobe: cell outputs updated
cell_bitmap  output  8  bitmap byte
cell_attr  output  8  attribute byte
cell_ink  output  8  ULA+ ink colour (0 when not fetched)
cell_paper  output  8  ULA+ paper colour (0 when not fetched)
overrun  output  1  sticky: strobe arrived while busy; cleared by reset only

Behaviour:
- Reset (rst_n low at a clk28 edge):
  - State goes to IDLE and the in-flight tag is cleared.
  - All outputs go to 0.
  - A video_data_valid arriving after reset is ignored, because there is no tag.
- Address arithmetic:
  - bitmap = {2'b00, y[7:6], y[2:0], y[5:3], x}.
  - attr = {2'b00, 3'b110, y[7:3], x}.
  - ink index = {attr[7:6], 1'b0, attr[2:0]}, placed in addr[5:0] with addr[14:6] = 0.
  - paper index = {attr[7:6], 1'b1, attr[5:3]}.
- States: IDLE, BMP, ATTR, INK, PAPER, DRAIN.
- IDLE:
  - On fetch_strobe, latch x/y/up_en (up_en is forced to 0 if UP_ENABLE = 0).
  - Go to BMP and drive req = 1, is_up = 0, addr = bitmap.
- Advance rule: in BMP/ATTR/INK/PAPER, a video_read_req_ack at an edge does three things:
  - sets the tag to the current state;
  - moves to the next state;
  - loads the next request's address in the same edge.
- Next-state order:
  - BMP -> ATTR.
  - ATTR -> INK if up_en, else DRAIN.
  - INK -> PAPER.
  - PAPER -> DRAIN.
  - In DRAIN, req = 0.
- Palette address timing: INK and PAPER need attr data. On entry to INK, drive req = 0 until the attr capture. At that edge compute the ink index from vd directly and set req = 1, is_up = 1.
- Without an ack the address and req are held unchanged. A read pre-empted by the arbiter simply produces no ack and is retried.
- Capture: video_data_valid with a tag loaded writes vd into the tagged field, then clears the tag.
- At most one read is in flight. An ack and a valid at the same edge are legal: capture the old tag and load the new tag.
- Completion:
  - The edge that captures the final field (attr when !up_en, paper when up_en) copies all four fields to the cell_* outputs.
  - The same edge pulses cell_ready for the following cycle and returns to IDLE.
  - cell_ink and cell_paper output 0 when !up_en.
  - Outputs hold until the next completion.
- busy = (state != IDLE). A fetch_strobe while busy is ignored and sets overrun.
- A strobe in the cycle after cell_ready is accepted.
- Latency with an uncontended arbiter: 2 clk28 per read. Strobe to cell_ready is ≤ 10 cycles with UP, ≤ 6 without.

Test Plan:
- x=5, y=0x47, up_en=0, arbiter model acks and returns 0xAA then 0x38:
  - addresses 0x0F05 then 0x1905, is_up=0;
  - cell_bitmap=0xAA, cell_attr=0x38, ink=paper=0;
  - one cell_ready pulse.
- up_en=1, attr returns 0xD6:
  - palette reads at index 0x36 then 0x3A with is_up=1;
  - returned 0x1C/0xE0 appear on cell_ink/cell_paper.
- Arbiter withholds ack for 5 cycles on the ATTR request:
  - address 0x1905 is held stable with req=1;
  - no extra capture occurs;
  - the result is correct.
- Second fetch_strobe 2 cycles after the first: it is ignored, overrun=1 and stays 1; the first cell completes normally.
- rst_n low for 1 cycle after the BMP ack, then video_data_valid with 0xFF:
  - all outputs are 0;
  - no cell_ready, req=0;
  - the next strobe works normally.
- x=31, y=191:
  - bitmap 0x17FF, attr 0x1AFF;
  - UP_ENABLE=0 with up_en=1 gives no is_up request.
